// File: rtl/layer2_pkg.sv
// layer2_pkg: shared states and geometry for the layer-2 frame controllers
package layer2_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
  localparam int L2_W = 13;
  localparam int L2_H = 17;
  localparam int L2_PIX = L2_W * L2_H;
endpackage

// File: rtl/pix_pos_counter.sv
// pix_pos_counter: column/row raster position counter with clear, enable and last-pixel flag
module pix_pos_counter #(
  parameter int W = 13,
  parameter int H = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [$clog2(W)-1:0] o_col,
  output logic [$clog2(H)-1:0] o_row,
  output logic                 o_last
);
  logic [$clog2(W)-1:0] r_col;
  logic [$clog2(H)-1:0] r_row;
  logic w_col_end, w_row_end;
  assign w_col_end = r_col == ($clog2(W))'(W - 1);
  assign w_row_end = r_row == ($clog2(H))'(H - 1);
  assign o_col = r_col;
  assign o_row = r_row;
  assign o_last = w_col_end & w_row_end;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      r_row <= w_col_end ? (w_row_end ? '0 : r_row + 1'b1) : r_row;
    end
  end
endmodule

// File: rtl/relu2_frame_sequencer.sv
// relu2_frame_sequencer: frame controller feeding the layer-2 ReLU and tracking its returned beats
module relu2_frame_sequencer
  import layer2_pkg::*;
#(
  parameter int IMAGE_WIDTH  = L2_W,
  parameter int IMAGE_HEIGHT = L2_H,
  parameter int PIPE_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            src_valid,
  output logic                            src_ready,
  output logic                            relu_valid_in,
  input  logic                            relu_valid_out,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] row,
  output logic                            first_pix,
  output logic                            last_pix,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            err_overflow
);
  localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int NW = $clog2(TOTAL + 1);
  seq_state_t r_state, w_next;
  logic [NW-1:0] r_in_cnt, r_out_cnt, w_in_nxt, w_out_nxt;
  logic w_ret, w_done, w_last, w_clr, r_frame_done, r_err;
  assign src_ready = r_state == RUN;
  assign relu_valid_in = src_valid & src_ready;
  assign busy = r_state != IDLE;
  assign w_ret = relu_valid_out & (r_state == RUN || r_state == DRAIN);
  assign w_in_nxt = r_in_cnt + NW'(relu_valid_in);
  assign w_out_nxt = r_out_cnt + NW'(w_ret && r_out_cnt != '1);
  assign w_done = w_out_nxt >= NW'(TOTAL);
  assign w_clr = abort || r_state == IDLE;
  assign first_pix = relu_valid_in && col == '0 && row == '0;
  assign last_pix = relu_valid_in & w_last;
  assign frame_done = r_frame_done;
  assign err_overflow = r_err;
  pix_pos_counter #(.W(IMAGE_WIDTH), .H(IMAGE_HEIGHT)) u_pos (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (relu_valid_in),
    .o_col (col),
    .o_row (row),
    .o_last(w_last)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = last_pix ? (w_done ? DONE : DRAIN) : RUN;
      DRAIN:   w_next = w_done ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_in_cnt     <= w_clr ? '0 : w_in_nxt;
      r_out_cnt    <= w_clr ? '0 : w_out_nxt;
      r_frame_done <= w_next == DONE;
      if (r_state == IDLE && start && !abort) r_err <= 1'b0;
      else if (w_ret && r_out_cnt >= w_in_nxt) r_err <= 1'b1;
    end
  end
  a_drain_depth: assert property (@(posedge clk) disable iff (rst)
    r_state == DRAIN |-> int'(r_out_cnt) + PIPE_LAT >= TOTAL);
  a_done_complete: assert property (@(posedge clk) disable iff (rst)
    r_frame_done |-> int'(r_out_cnt) >= TOTAL);
endmodule
